// File: rtl/mcu_spi_pixel_writer_pkg.sv
// Shared constants and state encodings for the MCU SPI pixel writer.
// Pure declarations: no latency, no flow control.
package psram_pkg;

  localparam int         BURST_PIXELS = 8;
  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam int         ADDR_W       = 22;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_READY
  } bank_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_CMD,
    RX_ADDR,
    RX_DATA,
    RX_IGNORE
  } rx_state_t;

endpackage

// File: rtl/mcu_spi_pixel_writer_if.sv
// Burst handoff to the PSRAM controller: req/ack plus an indexed read port into the presented bank.
// wr_req holds with stable fields until the controller pulses wr_ack.
interface mcu_spi_pixel_writer_if #(
  parameter int AW = psram_pkg::ADDR_W
);

  logic          wr_req;
  logic          wr_ack;
  logic [AW-1:0] wr_addr;
  logic [4:0]    wr_len;
  logic [3:0]    rd_idx;
  logic [15:0]   rd_data;

  modport master (
    output wr_req, wr_addr, wr_len, rd_data,
    input  wr_ack, rd_idx
  );

  modport slave (
    input  wr_req, wr_addr, wr_len, rd_data,
    output wr_ack, rd_idx
  );

endinterface

// File: rtl/mcu_spi_pixel_writer_spi_oversample_rx.sv
// Oversampled SPI mode-0 receiver: 2-FF synchronisers, sclk rising-edge detect, MSB-first byte assembly.
// byte_valid pulses one clk after the 8th edge; no backpressure, bytes must be consumed on the pulse.
module spi_oversample_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       cs_active
);

  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_d;
  logic       cs_d;
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic       sclk_rise;

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign cs_fall   = cs_d & ~cs_sync[1];
  assign cs_rise   = ~cs_d & cs_sync[1];
  assign cs_active = ~cs_sync[1];

  // cs synchroniser resets to the deselected level so reset release never fakes a frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync  <= 2'b00;
      cs_sync    <= 2'b11;
      mosi_sync  <= 2'b00;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b1;
      shift      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[0], sclk};
      cs_sync    <= {cs_sync[0], cs};
      mosi_sync  <= {mosi_sync[0], mosi};
      sclk_d     <= sclk_sync[1];
      cs_d       <= cs_sync[1];
      byte_valid <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift   <= {shift[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift, mosi_sync[1]};
        end
      end
    end
  end

endmodule

// File: rtl/mcu_spi_pixel_writer.sv
// Decodes MCU SPI write frames into RGB565 pixels and hands ping-pong bursts to the PSRAM controller.
// Pixel lands in a bank one clk after its low byte; pixels arriving with both banks READY are dropped (overflow).
module mcu_spi_pixel_writer
  import psram_pkg::*;
#(
  parameter int         BURST_PIXELS = psram_pkg::BURST_PIXELS,
  parameter logic [7:0] CMD_WRITE    = psram_pkg::CMD_WRITE,
  parameter int         ADDR_W       = psram_pkg::ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mcu_sclk,
  input  logic                          mcu_cs,
  input  logic                          mcu_mosi,
  mcu_spi_pixel_writer_if.master        wr,
  output logic                          frame_active,
  output logic                          err_cmd,
  output logic                          overflow
);

  localparam int         IDX_W    = $clog2(BURST_PIXELS);
  localparam logic [4:0] FULL_LEN = 5'(BURST_PIXELS);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       cs_fall;
  logic       cs_rise;

  spi_oversample_rx u_rx (
    .clk        (clk),
    .reset      (reset),
    .sclk       (mcu_sclk),
    .cs         (mcu_cs),
    .mosi       (mcu_mosi),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .cs_active  (frame_active)
  );

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [1:0]        addr_cnt;
  logic [ADDR_W-9:0] addr_sh;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        hi_byte;
  logic              hi_vld;
  logic              err_nxt;
  logic              pix_push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    pix_push  = 1'b0;
    if (cs_rise) begin
      state_nxt = RX_IDLE;
    end else begin
      case (state)
        RX_IDLE: if (cs_fall) state_nxt = RX_CMD;
        RX_CMD: begin
          if (byte_valid) begin
            if (byte_data == CMD_WRITE) begin
              state_nxt = RX_ADDR;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = RX_IGNORE;
            end
          end
        end
        RX_ADDR: if (byte_valid && addr_cnt == 2'd2) state_nxt = RX_DATA;
        RX_DATA: pix_push = byte_valid && hi_vld;
        default: ;
      endcase
    end
  end

  // Only the low ADDR_W bits of the 24-bit address survive, so the shifter keeps just enough history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt <= '0;
      addr_sh  <= '0;
      ptr      <= '0;
      hi_byte  <= '0;
      hi_vld   <= 1'b0;
      err_cmd  <= 1'b0;
    end else begin
      err_cmd <= err_nxt;
      if (state == RX_CMD) begin
        addr_cnt <= '0;
        hi_vld   <= 1'b0;
      end
      if (state == RX_ADDR && byte_valid) begin
        addr_cnt <= addr_cnt + 2'd1;
        addr_sh  <= (ADDR_W-8)'({addr_sh, byte_data});
        if (addr_cnt == 2'd2) ptr <= {addr_sh, byte_data};
      end
      if (state == RX_DATA && byte_valid) begin
        hi_byte <= byte_data;
        hi_vld  <= ~hi_vld;
        if (hi_vld) ptr <= ptr + 1'b1;
      end
    end
  end

  bank_state_t       bank_st   [2];
  logic [ADDR_W-1:0] bank_addr [2];
  logic [4:0]        bank_cnt  [2];
  logic [15:0]       bank_mem  [2][BURST_PIXELS];
  logic              fill_sel;
  logic              out_sel;
  logic              fill_open;
  logic              fill_done;
  logic              flush;
  logic              release_out;

  assign fill_open   = bank_st[fill_sel] != BANK_READY;
  assign fill_done   = pix_push && fill_open && (bank_cnt[fill_sel] + 5'd1 == FULL_LEN);
  assign flush       = cs_rise && bank_st[fill_sel] == BANK_FILLING;
  assign release_out = wr.wr_ack && wr.wr_req;

  // Banks fill and drain in strict alternation, so the oldest READY bank is always out_sel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        bank_st[b]   <= BANK_EMPTY;
        bank_addr[b] <= '0;
        bank_cnt[b]  <= '0;
      end
      fill_sel <= 1'b0;
      out_sel  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (pix_push) begin
        if (fill_open) begin
          if (bank_st[fill_sel] == BANK_EMPTY) bank_addr[fill_sel] <= ptr;
          bank_cnt[fill_sel] <= bank_cnt[fill_sel] + 5'd1;
          bank_st[fill_sel]  <= fill_done ? BANK_READY : BANK_FILLING;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (flush) bank_st[fill_sel] <= BANK_READY;
      if (fill_done || flush) fill_sel <= ~fill_sel;
      if (release_out) begin
        bank_st[out_sel]  <= BANK_EMPTY;
        bank_cnt[out_sel] <= '0;
        out_sel           <= ~out_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pix_push && fill_open)
      bank_mem[fill_sel][bank_cnt[fill_sel][IDX_W-1:0]] <= {hi_byte, byte_data};
  end

  assign wr.wr_req  = bank_st[out_sel] == BANK_READY;
  assign wr.wr_addr = bank_addr[out_sel];
  assign wr.wr_len  = bank_cnt[out_sel];

  always_comb begin
    wr.rd_data = '0;
    if ({1'b0, wr.rd_idx} < FULL_LEN)
      wr.rd_data = bank_mem[out_sel][wr.rd_idx[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_mcu_spi_pixel_writer.sv
// Bench: SPI frames from a vector table plus reset/backpressure sequences; bursts checked against a queue.
module tb_mcu_spi_pixel_writer;

  localparam int CLK_HALF = 10;
  localparam int SCK_HALF = 80;
  localparam int BP       = 8;

  typedef struct packed {
    logic [21:0] addr;
    logic [4:0]  len;
    logic [15:0] base;
  } burst_t;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  npix;
    logic        odd;
    logic [15:0] base;
    logic        exp_err;
    logic [3:0]  exp_bursts;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic mcu_sclk;
  logic mcu_cs;
  logic mcu_mosi;
  logic frame_active;
  logic err_cmd;
  logic overflow;
  logic ack_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int delivered = 0;
  int err_seen = 0;
  int d0;

  burst_t exp_q[$];
  vec_t   vecs [7];

  mcu_spi_pixel_writer_if wr_if ();

  mcu_spi_pixel_writer dut (
    .clk          (clk),
    .reset        (reset),
    .mcu_sclk     (mcu_sclk),
    .mcu_cs       (mcu_cs),
    .mcu_mosi     (mcu_mosi),
    .wr           (wr_if),
    .frame_active (frame_active),
    .err_cmd      (err_cmd),
    .overflow     (overflow)
  );

  always #CLK_HALF clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_begin();
    mcu_cs = 1'b0;
    #(2*SCK_HALF);
  endtask

  task automatic spi_end();
    #(SCK_HALF);
    mcu_cs = 1'b1;
    #(4*SCK_HALF);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      mcu_mosi = b[i];
      #(SCK_HALF);
      mcu_sclk = 1'b1;
      #(SCK_HALF);
      mcu_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [23:0] addr, input int npix,
                            input logic odd, input logic [15:0] base);
    logic [15:0] px;
    spi_begin();
    check("frame_active_in_frame", 32'(frame_active), 1);
    spi_byte(cmd);
    spi_byte(addr[23:16]);
    spi_byte(addr[15:8]);
    spi_byte(addr[7:0]);
    for (int k = 0; k < npix; k++) begin
      px = base + 16'(k);
      spi_byte(px[15:8]);
      spi_byte(px[7:0]);
    end
    if (odd) spi_byte(8'hA5);
    spi_end();
  endtask

  // Reference: consecutive chunks of BP pixels, addresses wrapping at 2^22.
  task automatic expect_frame(input logic [23:0] addr, input int npix, input logic [15:0] base);
    burst_t b;
    for (int s = 0; s < npix; s += BP) begin
      b.addr = 22'(addr + 24'(s));
      b.len  = 5'((npix - s < BP) ? npix - s : BP);
      b.base = base + 16'(s);
      exp_q.push_back(b);
    end
  endtask

  task automatic drain();
    int c = 0;
    repeat (20) @(negedge clk);
    while ((exp_q.size() != 0 || wr_if.wr_req) && c < 4000) begin
      @(negedge clk);
      c++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("wr_req_idle", 32'(wr_if.wr_req), 0);
    exp_q.delete();
  endtask

  // PSRAM controller model: waits two cycles, reads the bank through rd_idx, then acks.
  initial begin
    burst_t b;
    wr_if.wr_ack = 1'b0;
    wr_if.rd_idx = '0;
    forever begin
      @(negedge clk);
      if (ack_en && wr_if.wr_req) begin
        repeat (2) @(negedge clk);
        if (exp_q.size() == 0) begin
          check("unexpected_burst", 32'(wr_if.wr_req), 0);
        end else begin
          b = exp_q.pop_front();
          check("burst_addr", 32'(wr_if.wr_addr), 32'(b.addr));
          check("burst_len", 32'(wr_if.wr_len), 32'(b.len));
          for (int i = 0; i < int'(b.len); i++) begin
            wr_if.rd_idx = 4'(i);
            #1;
            check($sformatf("rd_data[%0d]", i), 32'(wr_if.rd_data), 32'(b.base + 16'(i)));
            @(negedge clk);
          end
          check("req_held_until_ack", 32'(wr_if.wr_req), 1);
          delivered++;
        end
        wr_if.wr_ack = 1'b1;
        @(negedge clk);
        wr_if.wr_ack = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (err_cmd === 1'b1) err_seen++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d so far bad", n_bad, n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    mcu_sclk = 1'b0;
    mcu_cs   = 1'b1;
    mcu_mosi = 1'b0;

    vecs[0] = '{8'h02, 24'h000010, 8'd8,  1'b0, 16'hF800, 1'b0, 4'd1};
    vecs[1] = '{8'h02, 24'h000100, 8'd20, 1'b0, 16'h1000, 1'b0, 4'd3};
    vecs[2] = '{8'h03, 24'h000050, 8'd4,  1'b0, 16'h2000, 1'b1, 4'd0};
    vecs[3] = '{8'h02, 24'h3FFFFF, 8'd3,  1'b0, 16'h3000, 1'b0, 4'd1};
    vecs[4] = '{8'h02, 24'h000020, 8'd2,  1'b1, 16'h4000, 1'b0, 4'd1};
    vecs[5] = '{8'h02, 24'hC00005, 8'd1,  1'b0, 16'h5000, 1'b0, 4'd1};
    vecs[6] = '{8'h02, 24'h0000F8, 8'd16, 1'b0, 16'h6000, 1'b0, 4'd2};

    repeat (3) @(negedge clk);
    check("rst_wr_req", 32'(wr_if.wr_req), 0);
    check("rst_wr_addr", 32'(wr_if.wr_addr), 0);
    check("rst_wr_len", 32'(wr_if.wr_len), 0);
    check("rst_frame_active", 32'(frame_active), 0);
    check("rst_err_cmd", 32'(err_cmd), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    ack_en = 1'b1;
    for (int v = 0; v < 7; v++) begin
      d0       = delivered;
      err_seen = 0;
      if (vecs[v].cmd == 8'h02) expect_frame(vecs[v].addr, int'(vecs[v].npix), vecs[v].base);
      send_frame(vecs[v].cmd, vecs[v].addr, int'(vecs[v].npix), vecs[v].odd, vecs[v].base);
      drain();
      check($sformatf("v%0d_err_pulses", v), err_seen, 32'(vecs[v].exp_err));
      check($sformatf("v%0d_bursts", v), delivered - d0, 32'(vecs[v].exp_bursts));
      check($sformatf("v%0d_overflow", v), 32'(overflow), 0);
      check($sformatf("v%0d_frame_idle", v), 32'(frame_active), 0);
    end

    // Controller stalled: two banks fill, the rest of the frame is dropped.
    ack_en = 1'b0;
    d0     = delivered;
    expect_frame(24'h000100, 16, 16'h7000);
    send_frame(8'h02, 24'h000100, 20, 1'b0, 16'h7000);
    repeat (10) @(negedge clk);
    check("held_wr_req", 32'(wr_if.wr_req), 1);
    check("held_wr_addr", 32'(wr_if.wr_addr), 32'h100);
    check("held_wr_len", 32'(wr_if.wr_len), 8);
    check("held_overflow", 32'(overflow), 1);
    ack_en = 1'b1;
    drain();
    check("held_bursts", delivered - d0, 2);
    check("overflow_sticky", 32'(overflow), 1);

    // Reset in the middle of pixel data, then a clean frame.
    ack_en = 1'b0;
    spi_begin();
    spi_byte(8'h02);
    spi_byte(8'h00);
    spi_byte(8'h00);
    spi_byte(8'h40);
    for (int k = 0; k < 5; k++) begin
      spi_byte(8'h12);
      spi_byte(8'h34);
    end
    spi_byte(8'h56);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_wr_req", 32'(wr_if.wr_req), 0);
    check("mid_rst_wr_addr", 32'(wr_if.wr_addr), 0);
    check("mid_rst_wr_len", 32'(wr_if.wr_len), 0);
    check("mid_rst_frame_active", 32'(frame_active), 0);
    check("mid_rst_err_cmd", 32'(err_cmd), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    mcu_cs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    ack_en = 1'b1;
    d0     = delivered;
    expect_frame(24'h000200, 8, 16'h9000);
    send_frame(8'h02, 24'h000200, 8, 1'b0, 16'h9000);
    drain();
    check("post_rst_bursts", delivered - d0, 1);
    check("post_rst_overflow", 32'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mcu_spi_pixel_writer.md
Name: mcu_spi_pixel_writer

Overview:
- Upstream feeder for the PSRAM framebuffer controller. Replaces the raw MCU SPI passthrough to PSRAM with a command-decoded pixel path.
- Oversamples the MCU SPI bus on the system clock and deserialises write frames into 16-bit RGB565 pixels.
- Collects pixels in ping-pong burst buffers and hands (address, length, data) bursts to the PSRAM controller through a req/ack handshake.
- Removes the need to stall LCD refill while the MCU owns the PSRAM pins.

Parameters:
- BURST_PIXELS, 8, pixels per bank; maximum burst length (power of 2, 2..16).
- CMD_WRITE, 8'h02, command byte that opens a pixel write frame.
- ADDR_W, 22, pixel address width.

Ports:
- clk  input  1  system clock; also the PSRAM controller clock.
- reset  input  1  asynchronous, active-low reset.
- mcu_sclk  input  1  MCU SPI clock, mode 0, asynchronous to clk.
- mcu_cs  input  1  MCU chip select, active low.
- mcu_mosi  input  1  MCU data, MSB first.
- wr_req  output  1  a bank holds a burst ready for the PSRAM controller.
- wr_ack  input  1  one-cycle pulse from the controller: burst written, bank released.
- wr_addr  output  ADDR_W  pixel address of the burst's first pixel.
- wr_len  output  5  number of valid pixels in the burst, 1..BURST_PIXELS.
- rd_idx  input  4  pixel index the controller reads within the presented bank.
- rd_data  output  16  pixel at rd_idx in the presented bank; combinational read.
- frame_active  output  1  synced mcu_cs is low.
- err_cmd  output  1  one-cycle pulse when a frame's command byte is not CMD_WRITE.
- overflow  output  1  sticky flag: a pixel was dropped; cleared only by reset.

Behaviour:
- Reset (asynchronous, active-low): wr_req=0, wr_addr=0, wr_len=0, frame_active=0, err_cmd=0, overflow=0, both banks empty, receive FSM in IDLE. rd_data is don't-care while wr_req=0.
- Sampling:
  - Each of mcu_sclk, mcu_cs, mcu_mosi passes through a 2-FF synchroniser.
  - An SCLK rising edge is detected on the synced sclk with one extra register. MOSI is captured on the same clk cycle the edge is detected.
  - Requirement: clk ≥ 4× mcu_sclk.
  - Bits are ignored while synced cs is high.
- Receive FSM:
  - IDLE: on synced cs falling edge, clear the bit counter and go to CMD.
  - CMD: after 8 bits, if the byte == CMD_WRITE go to ADDR; otherwise pulse err_cmd and go to IGNORE.
  - ADDR: receive 3 bytes as a 24-bit big-endian value. The low ADDR_W bits become the pixel pointer. Then go to DATA.
  - DATA: receive byte pairs, high byte first. Each completed pair is pushed into the fill bank at the pointer offset; the pointer then increments, wrapping at 2^ADDR_W.
  - IGNORE: discard bits until cs rises.
  - From any state, a synced cs rising edge returns to IDLE. A partial byte or an odd trailing byte is discarded.
- Banks:
  - Two banks of BURST_PIXELS×16. Each is EMPTY, FILLING or READY. Exactly one bank is the fill bank.
  - The first pixel into an EMPTY fill bank latches that bank's start address.
  - A fill bank becomes READY when it reaches BURST_PIXELS pixels, or on cs rising edge if it holds ≥1 pixel.
  - After becoming READY, the other bank becomes the fill bank.
  - A pixel arriving when the fill bank is not EMPTY/FILLING (both banks READY) is dropped and sets overflow. The pointer still advances.
- Output handshake:
  - wr_req=1 whenever a READY bank exists. The oldest READY bank is presented; bursts go out in strict fill order.
  - wr_addr, wr_len and rd_data stay stable while wr_req=1.
  - On wr_ack the presented bank becomes EMPTY. wr_req drops the next cycle unless the other bank is READY, in which case it stays high with the new bank's fields.
  - wr_ack while wr_req=0 is ignored.
- Simultaneous events: a bank becoming READY and a wr_ack in the same cycle are both honoured. A released bank can accept a pixel on the following cycle.
- Reset mid-frame: all state is discarded. A burst in flight to the controller is abandoned, and the controller must also be reset.

Decomposition:
- Shared package psram_pkg: CMD_WRITE, BURST_PIXELS, ADDR_W, bank-state and receive-state encodings.
- Natural sub-module: spi_oversample_rx. It holds the synchronisers, edge detect and byte assembly, and outputs byte_valid, byte_data, cs_fall, cs_rise.

Test Plan:
- Write frame 02 00 00 10 followed by 8 pixels 0xF800..0xF807 → one wr_req with wr_addr=0x10, wr_len=8; rd_idx 0..7 returns 0xF800..0xF807. Ack → wr_req=0.
- Frame with 20 pixels starting at address 0x100, controller acking after 2 cycles → bursts (0x100,8), (0x108,8), (0x110,4) in order. overflow=0.
- Same 20-pixel frame with wr_ack held off → first two bursts READY; pixel 17 sets overflow; after acks, only 16 pixels are delivered.
- Frame with command 0x03 → err_cmd pulses once; no wr_req for the whole frame.
- Frame 02 3F FF FF with 3 pixels → burst (0x3FFFFF,3); its 2nd pixel sits at offset 1, corresponding to pixel address 0 (wrap). Frame ending after 5 data bytes → wr_len=2.
- Assert reset low mid-DATA → all outputs at reset values; the next clean frame works normally.
